// File: rtl/fetch_pkg.sv
// Shared defaults, FSM state encoding and queue entry layout for the fetch queue.
package fetch_pkg;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_PC_STEP = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] pc;
      logic [DEF_DATA_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, flush, and count/full/empty status.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   input  logic                    flush,
   output logic [WIDTH-1:0]        head_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];
   assign do_push   = push && !full && !flush;
   assign do_pop    = pop && !empty && !flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Storage is reset so the head reads as zero until the first push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// Prefetch stage: owns the fetch PC, keeps one ROM request in flight and queues {pc, instr}.
// Defining FETCH_QUEUE_STATS_EN adds the statFetched/statDropped/statStall counters.
//
// state | meaning
// IDLE  | may issue a request when the queue has room and no redirect is present
// WAIT  | request outstanding, its response will be pushed
// DROP  | request outstanding, its response belongs to a squashed path
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DEPTH    = DEF_DEPTH,
   parameter int                PC_STEP  = DEF_PC_STEP,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic              memReady,
   input  logic [DATA_W-1:0] memData,
   input  logic              redirectValid,
   input  logic [ADDR_W-1:0] redirectPc,
   output logic              instrValid,
   output logic [DATA_W-1:0] instrData,
   output logic [ADDR_W-1:0] instrPc,
   input  logic              instrTake
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [31:0]       statFetched,
   output logic [31:0]       statDropped,
   output logic [31:0]       statStall
`endif
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = ADDR_W + DATA_W;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_req_q, mem_req_d;
   logic              fifo_push, fifo_pop;
   logic [ENT_W-1:0]  fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;

   assign fifo_pop = instrTake && !fifo_empty && !redirectValid;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = 1'b0;
      fifo_push  = 1'b0;
      if (redirectValid) begin
         fetch_pc_d = redirectPc;
      end
      unique case (state_q)
         IDLE: begin
            if (!redirectValid && (fifo_count < DEPTH_C)) begin
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (memReady) begin
               state_d = IDLE;
               if (!redirectValid) begin
                  fifo_push  = 1'b1;
                  fetch_pc_d = fetch_pc_q + STEP_C;
               end
            end else if (redirectValid) begin
               state_d = DROP;
            end
         end
         // The squashed response retires the request; fetchPc already holds the newest target.
         DROP: begin
            if (memReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         mem_addr_q <= RESET_PC;
         mem_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
      end
   end

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({fetch_pc_q, memData}),
      .pop       (fifo_pop),
      .flush     (redirectValid),
      .head_data (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign memReq     = mem_req_q;
   assign memAddr    = mem_addr_q;
   assign instrValid = !fifo_empty;
   assign {instrPc, instrData} = fifo_head;

`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] stat_fetched_q, stat_fetched_d;
   logic [31:0] stat_dropped_q, stat_dropped_d;
   logic [31:0] stat_stall_q, stat_stall_d;
   logic        drop_evt, stall_evt;

   always_comb begin
      drop_evt       = memReady && ((state_q == DROP) || ((state_q == WAIT) && redirectValid));
      stall_evt      = (state_q == IDLE) && fifo_full && !redirectValid;
      stat_fetched_d = stat_fetched_q + {31'd0, fifo_push};
      stat_dropped_d = stat_dropped_q + {31'd0, drop_evt};
      stat_stall_d   = stat_stall_q + {31'd0, stall_evt};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched_q <= '0;
         stat_dropped_q <= '0;
         stat_stall_q   <= '0;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_dropped_q <= stat_dropped_d;
         stat_stall_q   <= stat_stall_d;
      end
   end

   assign statFetched = stat_fetched_q;
   assign statDropped = stat_dropped_q;
   assign statStall   = stat_stall_q;
`else
   logic unused_full;
   assign unused_full = fifo_full;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: default instance plus a RESET_PC near the top of the address space.
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        memReq, memReady, redirectValid, instrValid, instrTake;
   logic [31:0] memAddr, memData, redirectPc, instrData, instrPc;
   logic        w_memReq, w_memReady, w_redirectValid, w_instrValid, w_instrTake;
   logic [31:0] w_memAddr, w_memData, w_redirectPc, w_instrData, w_instrPc;
`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] statFetched, statDropped, statStall;
   logic [31:0] w_statFetched, w_statDropped, w_statStall;
`endif

   int   errors = 0;
   int   checks = 0;
   bit   rom_en = 1'b0;
   int   rom_lat = 1;
   int   rom_cnt = 0;
   int   rdy_cnt = 0;
   logic [31:0] rom_addr = '0;

   always #5 clk = ~clk;

   fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .memReq(memReq), .memAddr(memAddr), .memReady(memReady),
      .memData(memData), .redirectValid(redirectValid), .redirectPc(redirectPc),
      .instrValid(instrValid), .instrData(instrData), .instrPc(instrPc), .instrTake(instrTake)
`ifdef FETCH_QUEUE_STATS_EN
      , .statFetched(statFetched), .statDropped(statDropped), .statStall(statStall)
`endif
   );

   fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst_n(rst_n), .memReq(w_memReq), .memAddr(w_memAddr), .memReady(w_memReady),
      .memData(w_memData), .redirectValid(w_redirectValid), .redirectPc(w_redirectPc),
      .instrValid(w_instrValid), .instrData(w_instrData), .instrPc(w_instrPc), .instrTake(w_instrTake)
`ifdef FETCH_QUEUE_STATS_EN
      , .statFetched(w_statFetched), .statDropped(w_statDropped), .statStall(w_statStall)
`endif
   );

   // ROM model for the default instance: data = 0xDEAD0000 ^ addr after rom_lat cycles.
   initial forever begin
      @(posedge clk);
      #2;
      if (rom_en) begin
         memReady = 1'b0;
         if (rom_cnt > 0) begin
            rom_cnt--;
            if (rom_cnt == 0) begin
               memReady = 1'b1;
               memData  = 32'hDEAD_0000 ^ rom_addr;
               rdy_cnt++;
            end
         end
         if (memReq) begin
            rom_addr = memAddr;
            rom_cnt  = rom_lat;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rom_en = 1'b0; rom_cnt = 0; rdy_cnt = 0;
      memReady = 1'b0; memData = '0; redirectValid = 1'b0; redirectPc = '0; instrTake = 1'b0;
      w_memReady = 1'b0; w_memData = '0; w_redirectValid = 1'b0; w_redirectPc = '0; w_instrTake = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_req(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (memReq) seen = 1'b1;
      end
   endtask

   task automatic wait_valid(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (instrValid) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      tick();
      tick();
      checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rst_memReq: got %b want 0", memReq); end
      checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL rst_memAddr: got %h want 00000000", memAddr); end
      checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rst_instrValid: got %b want 0", instrValid); end
      checks++; if (instrData !== 32'h0) begin errors++; $display("FAIL rst_instrData: got %h want 00000000", instrData); end
      checks++; if (instrPc !== 32'h0) begin errors++; $display("FAIL rst_instrPc: got %h want 00000000", instrPc); end
      checks++; if (w_memAddr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL rst_w_memAddr: got %h want fffffff8", w_memAddr); end
`ifdef FETCH_QUEUE_STATS_EN
      checks++; if (statFetched !== 32'h0 || statDropped !== 32'h0 || statStall !== 32'h0) begin
         errors++; $display("FAIL rst_stats: got %h/%h/%h want 0/0/0", statFetched, statDropped, statStall); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] exp_addr [4];
      int req_cnt = 0;
      int pop_cnt = 0;
      exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset();
      rom_en = 1'b1; rom_lat = 1; instrTake = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (memReq) begin
            checks++; if (req_cnt != rdy_cnt) begin errors++; $display("FAIL stream_overlap: responses %0d want %0d", rdy_cnt, req_cnt); end
            if (req_cnt < 4) begin
               checks++; if (memAddr !== exp_addr[req_cnt]) begin errors++; $display("FAIL stream_addr%0d: got %h want %h", req_cnt, memAddr, exp_addr[req_cnt]); end
            end
            req_cnt++;
         end
         if (instrValid && instrTake) begin
            if (pop_cnt < 3) begin
               checks++; if (instrPc !== exp_addr[pop_cnt]) begin errors++; $display("FAIL stream_pc%0d: got %h want %h", pop_cnt, instrPc, exp_addr[pop_cnt]); end
               checks++; if (instrData !== (32'hDEAD_0000 | exp_addr[pop_cnt])) begin errors++; $display("FAIL stream_data%0d: got %h want %h", pop_cnt, instrData, 32'hDEAD_0000 | exp_addr[pop_cnt]); end
            end
            pop_cnt++;
         end
      end
      checks++; if (req_cnt < 4) begin errors++; $display("FAIL stream_req_count: got %0d want >=4", req_cnt); end
      checks++; if (pop_cnt < 3) begin errors++; $display("FAIL stream_pop_count: got %0d want >=3", pop_cnt); end
   endtask

   task automatic test_full();
      int nreq = 0;
      logic [31:0] addr = '0;
      do_reset();
      rom_en = 1'b1; rom_lat = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (memReq) nreq++;
      end
      checks++; if (nreq != 4) begin errors++; $display("FAIL full_reqs: got %0d want 4", nreq); end
      checks++; if (instrValid !== 1'b1 || instrPc !== 32'h0) begin errors++; $display("FAIL full_head: got v=%b pc=%h want v=1 pc=00000000", instrValid, instrPc); end
      instrTake = 1'b1;
      tick();
      instrTake = 1'b0;
      checks++; if (instrPc !== 32'h4) begin errors++; $display("FAIL full_pop_pc: got %h want 00000004", instrPc); end
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (memReq) begin nreq++; addr = memAddr; end
      end
      checks++; if (nreq != 1) begin errors++; $display("FAIL full_refill_reqs: got %0d want 1", nreq); end
      checks++; if (addr !== 32'h10) begin errors++; $display("FAIL full_refill_addr: got %h want 00000010", addr); end
   endtask

   task automatic test_redirect_wait();
      bit seen;
      do_reset();
      rom_en = 1'b1; rom_lat = 3;
      wait_req(5, seen);
      wait_req(8, seen);
      checks++; if (!seen || memAddr !== 32'h4) begin errors++; $display("FAIL rw_second_req: seen=%b addr=%h want addr 00000004", seen, memAddr); end
      tick();
      checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL rw_pre_valid: got %b want 1", instrValid); end
      redirectValid = 1'b1; redirectPc = 32'h100;
      tick();
      redirectValid = 1'b0;
      checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rw_flush: got %b want 0", instrValid); end
      wait_req(10, seen);
      checks++; if (!seen || memAddr !== 32'h100) begin errors++; $display("FAIL rw_new_addr: seen=%b addr=%h want 00000100", seen, memAddr); end
      checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rw_stale_push: got valid %b want 0", instrValid); end
      wait_valid(10, seen);
      checks++; if (!seen || instrPc !== 32'h100 || instrData !== 32'hDEAD_0100) begin
         errors++; $display("FAIL rw_first_pc: seen=%b pc=%h data=%h want 00000100/dead0100", seen, instrPc, instrData); end
`ifdef FETCH_QUEUE_STATS_EN
      checks++; if (statFetched !== 32'd2 || statDropped !== 32'd1) begin errors++; $display("FAIL rw_stats: got %0d/%0d want 2/1", statFetched, statDropped); end
`endif
   endtask

   task automatic test_redirect_ready_take();
      bit seen;
      do_reset();
      wait_req(5, seen);
      tick();
      memReady = 1'b1; memData = 32'hDEAD_0000;
      tick();
      memReady = 1'b0;
      checks++; if (instrValid !== 1'b1 || instrPc !== 32'h0) begin errors++; $display("FAIL rrt_pre: got v=%b pc=%h want 1/00000000", instrValid, instrPc); end
      wait_req(5, seen);
      tick();
      memReady = 1'b1; memData = 32'hDEAD_0004;
      redirectValid = 1'b1; redirectPc = 32'h200; instrTake = 1'b1;
      tick();
      memReady = 1'b0; redirectValid = 1'b0; instrTake = 1'b0;
      checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rrt_flush: got %b want 0", instrValid); end
      wait_req(5, seen);
      checks++; if (!seen || memAddr !== 32'h200) begin errors++; $display("FAIL rrt_addr: seen=%b addr=%h want 00000200", seen, memAddr); end
      tick();
      memReady = 1'b1; memData = 32'hDEAD_0200;
      tick();
      memReady = 1'b0;
      checks++; if (instrValid !== 1'b1 || instrPc !== 32'h200 || instrData !== 32'hDEAD_0200) begin
         errors++; $display("FAIL rrt_push: got v=%b pc=%h data=%h want 1/00000200/dead0200", instrValid, instrPc, instrData); end
      instrTake = 1'b1;
      tick();
      instrTake = 1'b0;
      checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rrt_single_entry: got %b want 0", instrValid); end
`ifdef FETCH_QUEUE_STATS_EN
      checks++; if (statFetched !== 32'd2 || statDropped !== 32'd1) begin errors++; $display("FAIL rrt_stats: got %0d/%0d want 2/1", statFetched, statDropped); end
`endif
   endtask

   task automatic test_back_to_back();
      bit seen;
      do_reset();
      rom_en = 1'b1; rom_lat = 4;
      wait_req(5, seen);
      tick();
      redirectValid = 1'b1; redirectPc = 32'h300;
      tick();
      redirectPc = 32'h400;
      tick();
      redirectValid = 1'b0;
      wait_req(8, seen);
      checks++; if (!seen || memAddr !== 32'h400) begin errors++; $display("FAIL b2b_addr: seen=%b addr=%h want 00000400", seen, memAddr); end
      checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", instrValid); end
      wait_valid(10, seen);
      checks++; if (!seen || instrPc !== 32'h400 || instrData !== 32'hDEAD_0400) begin
         errors++; $display("FAIL b2b_pc: seen=%b pc=%h data=%h want 00000400/dead0400", seen, instrPc, instrData); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_dat [3];
      logic [31:0] hold = '0;
      bit pend = 1'b0;
      int resp = 0;
      int pops = 0;
      exp_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      exp_dat = '{32'h0000_0007, 32'h0000_0003, 32'hFFFF_FFFF};
      do_reset();
      w_instrTake = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         w_memReady = 1'b0;
         if (pend) begin
            w_memReady = 1'b1; w_memData = ~hold; pend = 1'b0; resp++;
         end
         if (w_memReq && resp < 3) begin
            pend = 1'b1; hold = w_memAddr;
         end
         if (w_instrValid) begin
            if (pops < 3) begin
               checks++; if (w_instrPc !== exp_pc[pops] || w_instrData !== exp_dat[pops]) begin
                  errors++; $display("FAIL wrap_entry%0d: got %h/%h want %h/%h", pops, w_instrPc, w_instrData, exp_pc[pops], exp_dat[pops]); end
            end
            pops++;
         end
      end
      checks++; if (pops != 3) begin errors++; $display("FAIL wrap_pops: got %0d want 3", pops); end
`ifdef FETCH_QUEUE_STATS_EN
      checks++; if (w_statFetched !== 32'd3 || w_statDropped !== 32'd0) begin errors++; $display("FAIL wrap_stats: got %0d/%0d want 3/0", w_statFetched, w_statDropped); end
`endif
   endtask

   task automatic test_reset_in_wait();
      bit seen;
      do_reset();
      wait_req(5, seen);
      tick();
      memReady = 1'b1; memData = 32'h1234_5678;
      tick();
      memReady = 1'b0;
      checks++; if (instrValid !== 1'b1 || instrData !== 32'h1234_5678) begin errors++; $display("FAIL riw_pre: got v=%b data=%h want 1/12345678", instrValid, instrData); end
      wait_req(5, seen);
      tick();
      rst_n = 1'b0;
      tick();
      memReady = 1'b1; memData = 32'hBAD0_BAD0;
      checks++; if (memReq !== 1'b0 || memAddr !== 32'h0 || instrValid !== 1'b0 || instrData !== 32'h0 || instrPc !== 32'h0) begin
         errors++; $display("FAIL riw_reset_vals: got req=%b addr=%h v=%b data=%h pc=%h want 0/0/0/0/0", memReq, memAddr, instrValid, instrData, instrPc); end
      tick();
      rst_n = 1'b1;
      tick();
      memReady = 1'b0;
      checks++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin errors++; $display("FAIL riw_first_req: got req=%b addr=%h want 1/00000000", memReq, memAddr); end
      checks++; if (instrValid !== 1'b0 || instrData !== 32'h0) begin errors++; $display("FAIL riw_no_push: got v=%b data=%h want 0/00000000", instrValid, instrData); end
`ifdef FETCH_QUEUE_STATS_EN
      checks++; if (statFetched !== 32'd0) begin errors++; $display("FAIL riw_stats: got %0d want 0", statFetched); end
`endif
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_ready_take();
      test_back_to_back();
      test_wrap();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Clocked, parametrised successor to the toggle-handshake fetch stage.
- Decouples instruction memory from issue through a DEPTH-entry prefetch FIFO.
- Owns the fetch PC and supports a single-cycle branch redirect with a flush.
- Sits between the instruction ROM (request/ready port) and the issue stage (valid/take port).

Parameters:
- DATA_W, 32: instruction width.
- ADDR_W, 32: PC/address width.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PC_STEP, 4: PC increment per fetched instruction.
- RESET_PC, 0: fetch PC after reset.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memReq  out  1  one-cycle request pulse to ROM.
- memAddr  out  ADDR_W  request address; valid when memReq=1, held until response.
- memReady  in  1  one-cycle response pulse; memData valid in that cycle.
- memData  in  DATA_W  ROM read data.
- redirectValid  in  1  branch redirect, one cycle.
- redirectPc  in  ADDR_W  redirect target.
- instrValid  out  1  FIFO head valid.
- instrData  out  DATA_W  head instruction.
- instrPc  out  ADDR_W  PC of head instruction.
- instrTake  in  1  consumer pops the head when instrValid=1.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - memReq=0, memAddr=RESET_PC, instrValid=0, instrData=0, instrPc=0.
  - FIFO count=0, fetchPc=RESET_PC, state=IDLE.
- FSM states:
  - IDLE: if count<DEPTH and no redirect this cycle, pulse memReq with memAddr=fetchPc, then go to WAIT.
  - WAIT: on memReady, push {fetchPc, memData}, set fetchPc+=PC_STEP (mod 2^ADDR_W), go to IDLE.
  - DROP: on memReady, discard the data and go to IDLE; fetchPc is unchanged (already redirected).
- Only one request is outstanding at any time. Peak throughput is one instruction per 2 cycles plus ROM latency.
- Push/pop:
  - A push and an instrTake in the same cycle leave count unchanged.
  - instrTake with instrValid=0 is ignored.
  - A push is never attempted when full: the request is gated by count<DEPTH at issue time.
- instrValid and outputs come from registered FIFO head. Zero-bubble: data pushed at cycle t is visible at t+1.
- Redirect (highest priority), taking effect at cycle t:
  - FIFO is flushed (count=0, instrValid=0 at t+1) and fetchPc=redirectPc.
  - IDLE: no memReq at t; first request with redirectPc at t+1.
  - WAIT with no memReady at t: go to DROP.
  - WAIT with memReady at t: that response is dropped and the state goes to IDLE.
  - DROP: stays in DROP.
  - An instrTake at t is ignored.
- Back-to-back redirects: the last one wins.
- Wrap: FIFO pointers wrap modulo DEPTH; PC wraps modulo 2^ADDR_W.
- Reset mid-operation: an outstanding ROM response arriving after reset is ignored, because the state is IDLE.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- When defined, the block adds these outputs:
  - statFetched (32b): increments on each push.
  - statDropped (32b): increments on each response discarded in DROP or at redirect.
  - statStall (32b): increments on each IDLE cycle blocked by a full FIFO.
- All counters reset to 0 and wrap.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - the FSM state enum (IDLE, WAIT, DROP);
  - the default widths;
  - the FIFO entry typedef {pc, instr}.
- Sub-module sync_fifo (parametrised width/depth, push/pop/flush, count/full/empty) is instantiated once. The FSM and PC logic stay in fetch_queue.

Test Plan:
- Reset, ROM latency 1, instrTake held 1 -> memAddr sequence 0,4,8,12; instrPc follows 0,4,8 with matching instrData; memReq never high twice without an intervening memReady.
- instrTake held 0, DEPTH=4 -> exactly 4 pushes, count=4, memReq stays 0; then one take -> exactly one new memReq at fetchPc=16.
- Redirect to 0x100 while in WAIT, ROM latency 3 -> stale response dropped, instrValid=0 next cycle, next memAddr=0x100, first instrPc=0x100.
- Redirect in the same cycle as memReady and instrTake -> response dropped, no pop counted, FIFO empty, next request at redirectPc.
- RESET_PC=0xFFFFFFF8, PC_STEP=4 -> instrPc 0xFFFFFFF8, 0xFFFFFFFC, 0x0; with FETCH_QUEUE_STATS_EN, statFetched=3 and statDropped=0.
- rst_n asserted while in WAIT, then a late memReady -> no push, outputs hold reset values, first request at RESET_PC.
